spi_byte_fifo: RTL
==================

Name: spi_byte_fifo

Overview:
- Synchronous byte FIFO with programmable watermark. It sits between the SPI register block and the SPI shift datapath.
- One instance serves as the TX FIFO: the register block writes, and the datapath pops into the TX shift register.
- One instance serves as the RX FIFO: the datapath writes received bytes, and the register block pops on data-register reads.
- First-word-fall-through read, occupancy count, watermark flag, and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8, width of each FIFO entry in bits.
- DEPTH, 8, number of entries; must be a power of two, ≥2.
- MARK_MODE, 0, watermark sense. 0 = TX sense: mark_o=1 when count_o ≤ water_mark_i. 1 = RX sense: mark_o=1 when count_o > water_mark_i.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- flush_i  input  1  synchronous clear of contents and error flags.
- wr_i  input  1  push request.
- wr_data_i  input  DATA_W  push data.
- rd_i  input  1  pop request.
- rd_data_o  output  DATA_W  head entry; first-word-fall-through.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- water_mark_i  input  3  watermark threshold, zero-extended to count width.
- mark_o  output  1  watermark flag, per MARK_MODE.
- overflow_o  output  1  sticky: a push was attempted while full and was not accepted.
- underflow_o  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset:
  - Applies on the rising edge of clk with rst_n=0.
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Outputs after reset: empty_o=1, full_o=0, count_o=0, rd_data_o=0. mark_o is 1 for MARK_MODE=0 and 0 for MARK_MODE=1.
  - Storage array is not reset.
- Reset mid-operation discards all contents. The next cycle behaves as post-reset.
- Priority: rst_n > flush_i > push/pop.
  - flush_i=1 gives the same pointer, count and flag state as reset, without touching storage.
  - Any wr_i/rd_i in the flush cycle is ignored.
- Push accepted = wr_i & (!full | rd_i). On accept: mem[wr_ptr] ← wr_data_i, and wr_ptr increments modulo DEPTH.
- Pop accepted = rd_i & !empty. On accept, rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both are accepted, or when neither is accepted.
- Full with wr_i & rd_i in the same cycle: both are accepted and the count stays DEPTH. No overflow is flagged.
- Empty with wr_i & rd_i in the same cycle:
  - The push is accepted and the pop is rejected.
  - underflow is set.
  - Count becomes 1 and the written byte appears on rd_data_o next cycle.
- Full with wr_i only: the push is dropped, contents are unchanged, and overflow is set next cycle.
- Empty with rd_i only: there is no pointer change, and underflow is set next cycle.
- Error flags stay set until flush or reset.
- rd_data_o = empty ? 0 : mem[rd_ptr]. This is combinational from registered state.
  - Valid in the cycle after the push that made the FIFO non-empty.
  - Write-to-read latency is 1 cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count_o distinguishes full from empty.
- full_o, empty_o and mark_o are combinational from count. water_mark_i may change at any time, and mark_o follows it in the same cycle.
- A water_mark_i value ≥ DEPTH is legal. With MARK_MODE=0, mark_o stays 1. With MARK_MODE=1, mark_o stays 0.
- No X on any output after reset.

Test Plan:
- Reset then idle → empty_o=1, full_o=0, count_o=0, rd_data_o=0x00, overflow_o=0, underflow_o=0.
- Push 0x11..0x88 (8 bytes), then push 0x99 → full_o=1 after the 8th push, and count_o=8. The 9th push sets overflow_o. Popping 8 bytes returns 0x11..0x88 in order, and then empty_o=1.
- Fill 8 bytes, then wr_i=rd_i=1 with 0xAA for 8 cycles → count_o stays 8 and overflow_o stays 0. The pops return the original 8 bytes, then the 8 × 0xAA entries drain, exercising pointer wrap.
- Empty FIFO, wr_i=rd_i=1 with 0x5C → underflow_o=1, count_o=1, rd_data_o=0x5C the next cycle.
- MARK_MODE=1, water_mark_i=3: push 4 bytes → mark_o goes 0→1 on the 4th push (count 4). Pop 1 → mark_o=0. With MARK_MODE=0 and water_mark_i=2, mark_o=1 at counts 0–2 and 0 at count 3.
- FIFO holding 5 bytes with overflow_o set; assert flush_i together with wr_i → next cycle count_o=0, empty_o=1 and overflow_o=0, with the write ignored. Repeat with rst_n=0 instead of flush_i, with the same result.

Source files
------------

// File: rtl/spi_byte_fifo_if.sv
// spi_byte_fifo_if: push/pop/status bundle between a FIFO user (master) and the FIFO (slave).
interface spi_byte_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              flush_i;
  logic              wr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              rd_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              full_o;
  logic              empty_o;
  logic [CW-1:0]     count_o;
  logic [2:0]        water_mark_i;
  logic              mark_o;
  logic              overflow_o;
  logic              underflow_o;
  modport master (
    output flush_i, wr_i, wr_data_i, rd_i, water_mark_i,
    input  rd_data_o, full_o, empty_o, count_o, mark_o, overflow_o, underflow_o
  );
  modport slave (
    input  flush_i, wr_i, wr_data_i, rd_i, water_mark_i,
    output rd_data_o, full_o, empty_o, count_o, mark_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: first-word-fall-through byte FIFO with watermark and sticky overflow/underflow flags.
module spi_byte_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter bit MARK_MODE = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  spi_byte_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = CW > 3 ? CW : 3;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              full, empty, push, pop;
  logic [XW-1:0]     cnt_x, wm_x;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  // a push into a full FIFO is only taken when a pop frees the slot in the same cycle
  assign push  = bus.wr_i & (~full | bus.rd_i);
  assign pop   = bus.rd_i & ~empty;
  always_comb begin
    wr_ptr_d = bus.flush_i ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = bus.flush_i ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = bus.flush_i ? '0 : count_q + CW'(push) - CW'(pop);
    ovf_d    = ~bus.flush_i & (ovf_q | (bus.wr_i & ~push));
    unf_d    = ~bus.flush_i & (unf_q | (bus.rd_i & empty));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush_i && push) mem_q[wr_ptr_q] <= bus.wr_data_i;
  end
  assign cnt_x           = XW'(count_q);
  assign wm_x            = XW'(bus.water_mark_i);
  assign bus.rd_data_o   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.count_o     = count_q;
  assign bus.mark_o      = MARK_MODE ? (cnt_x > wm_x) : (cnt_x <= wm_x);
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
endmodule
